// File: rtl/seg_scan_pkg.sv
// Shared glyph constants, receiver FSM states and the segment-to-nibble decoder
// for the 7-segment scan-bus receiver.
package seg_scan_pkg;

  // Glyphs in normalised (active-high) {g,f,e,d,c,b,a} order.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    Hunt,
    Collect,
    Publish
  } scan_state_e;

  typedef struct packed {
    logic       bad;
    logic       blank;
    logic [3:0] nib;
  } glyph_dec_t;

  function automatic glyph_dec_t seg_to_nib(input logic [6:0] seg);
    glyph_dec_t d;
    d.bad   = 1'b0;
    d.blank = 1'b0;
    d.nib   = 4'h0;
    case (seg)
      GLYPH_0:     d.nib = 4'h0;
      GLYPH_1:     d.nib = 4'h1;
      GLYPH_2:     d.nib = 4'h2;
      GLYPH_3:     d.nib = 4'h3;
      GLYPH_4:     d.nib = 4'h4;
      GLYPH_5:     d.nib = 4'h5;
      GLYPH_6:     d.nib = 4'h6;
      GLYPH_7:     d.nib = 4'h7;
      GLYPH_8:     d.nib = 4'h8;
      GLYPH_9:     d.nib = 4'h9;
      GLYPH_A:     d.nib = 4'hA;
      GLYPH_B:     d.nib = 4'hB;
      GLYPH_C:     d.nib = 4'hC;
      GLYPH_D:     d.nib = 4'hD;
      GLYPH_E:     d.nib = 4'hE;
      GLYPH_F:     d.nib = 4'hF;
      GLYPH_BLANK: d.blank = 1'b1;
      default:     d.bad = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_scan_stable.sv
// Synchronises the scan bus, normalises polarity and emits one capture pulse per
// digit slot once the select/segment pair has held steady long enough.
module seg_scan_stable
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter int unsigned STABLE_CNT  = 8,
  parameter int unsigned IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DIGITS-1:0] sel_i,
  input  logic [6:0]        seg_i,
  output logic              capture_o,
  output logic [IDX_W-1:0]  cap_idx_o,
  output logic [6:0]        cap_seg_o
);

  localparam logic [7:0] CntTop = 8'(STABLE_CNT - 1);

  logic [DIGITS-1:0] sel_s1_q, sel_s2_q, sel_n;
  logic [6:0]        seg_s1_q, seg_s2_q, seg_n;
  logic [DIGITS+6:0] pair_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              changed, one_hot, capture_d;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
    end else begin
      sel_s1_q <= sel_i;
      sel_s2_q <= sel_s1_q;
      seg_s1_q <= seg_i;
      seg_s2_q <= seg_s1_q;
    end
  end

  assign sel_n   = SEL_ACT_LOW ? ~sel_s2_q : sel_s2_q;
  assign seg_n   = SEG_ACT_LOW ? ~seg_s2_q : seg_s2_q;
  assign changed = ({sel_n, seg_n} != pair_q);
  // Guard/ghost intervals (no select or several selects) keep counting but never capture.
  assign one_hot = (sel_n != '0) && ((sel_n & (sel_n - DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_n[i]) idx = IDX_W'(i);
    end
  end

  // Saturating at CntTop makes the capture fire exactly once per stable run.
  always_comb begin
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q == CntTop) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    capture_d = one_hot && (cnt_d == CntTop) && (changed || (cnt_q != CntTop));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pair_q    <= '0;
      cnt_q     <= '0;
      capture_o <= 1'b0;
      cap_idx_o <= '0;
      cap_seg_o <= '0;
    end else begin
      pair_q    <= {sel_n, seg_n};
      cnt_q     <= cnt_d;
      capture_o <= capture_d;
      cap_idx_o <= idx;
      cap_seg_o <= seg_n;
    end
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Scan-bus receiver: decodes captured digit slots into frames and publishes them.
// Optional SEG_SCAN_RX_CHANGE_ONLY_EN suppresses frame_valid for unchanged frames.
module seg_scan_rx
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter int unsigned STABLE_CNT  = 8,
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DIGITS-1:0]     seg_sel,
  input  logic [6:0]            seg_ment,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_blank,
  output logic [DIGITS-1:0]     digit_bad,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  frame_stale
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoTop = TmoW'(TIMEOUT_CYC);

  logic            capture;
  logic [IdxW-1:0] cap_idx;
  logic [6:0]      cap_seg;
  glyph_dec_t      dec;

  scan_state_e state_q, state_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, val_q, val_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, blank_q, blank_d;
  logic [DIGITS-1:0]   sh_bad_q, sh_bad_d, bad_q, bad_d;
  logic                fv_q, fv_d, err_q, err_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                store, clear;

  seg_scan_stable #(
    .DIGITS      (DIGITS),
    .SEL_ACT_LOW (SEL_ACT_LOW),
    .SEG_ACT_LOW (SEG_ACT_LOW),
    .STABLE_CNT  (STABLE_CNT),
    .IDX_W       (IdxW)
  ) u_stable (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .sel_i     (seg_sel),
    .seg_i     (seg_ment),
    .capture_o (capture),
    .cap_idx_o (cap_idx),
    .cap_seg_o (cap_seg)
  );

  assign dec = seg_to_nib(cap_seg);

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    sh_val_d   = sh_val_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    val_d      = val_q;
    blank_d    = blank_q;
    bad_d      = bad_q;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    store      = 1'b0;
    clear      = 1'b0;
    tmo_d      = (tmo_q == TmoTop) ? tmo_q : tmo_q + TmoW'(1);

    unique case (state_q)
      Hunt: begin
        if (capture && (cap_idx == '0)) begin
          clear   = 1'b1;
          store   = 1'b1;
          state_d = Collect;
        end
      end
      Collect: begin
        if (capture) begin
          store = 1'b1;
          // Digit 0 again means the scanner wrapped before we saw every digit.
          if (cap_idx == '0) begin
            clear = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      Publish: begin
        val_d   = sh_val_q;
        blank_d = sh_blank_q;
        bad_d   = sh_bad_q;
`ifdef SEG_SCAN_RX_CHANGE_ONLY_EN
        fv_d    = ({sh_val_q, sh_blank_q, sh_bad_q} != {val_q, blank_q, bad_q});
`else
        fv_d    = 1'b1;
`endif
        seen_d  = '0;
        tmo_d   = '0;
        state_d = Hunt;
      end
      default: state_d = Hunt;
    endcase

    if (clear) begin
      sh_val_d   = '0;
      sh_blank_d = '0;
      sh_bad_d   = '0;
      seen_d     = '0;
    end
    if (store) begin
      sh_val_d[4*int'(cap_idx) +: 4] = dec.nib;
      sh_blank_d[cap_idx]            = dec.blank;
      sh_bad_d[cap_idx]              = dec.bad;
      seen_d[cap_idx]                = 1'b1;
    end
    if ((state_d == Collect) && (seen_d == '1)) state_d = Publish;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= Hunt;
      seen_q     <= '0;
      sh_val_q   <= '0;
      sh_blank_q <= '0;
      sh_bad_q   <= '0;
      val_q      <= '0;
      blank_q    <= '0;
      bad_q      <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      sh_val_q   <= sh_val_d;
      sh_blank_q <= sh_blank_d;
      sh_bad_q   <= sh_bad_d;
      val_q      <= val_d;
      blank_q    <= blank_d;
      bad_q      <= bad_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign digit_val   = val_q;
  assign digit_blank = blank_q;
  assign digit_bad   = bad_q;
  assign frame_valid = fv_q;
  assign frame_err   = err_q;
  assign frame_stale = (tmo_q == TmoTop);

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: decode table, directed corner cases and randomised slot
// streams checked against a frame-level reference model.
module tb_seg_scan_rx;

  localparam int unsigned StableCnt = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  seg_sel = 4'hF;
  logic [6:0]  seg_ment = 7'h7F;
  logic [15:0] digit_val;
  logic [3:0]  digit_blank, digit_bad;
  logic        frame_valid, frame_err, frame_stale;

  seg_scan_rx #(
    .DIGITS      (4),
    .SEL_ACT_LOW (1'b1),
    .SEG_ACT_LOW (1'b1),
    .STABLE_CNT  (8),
    .TIMEOUT_CYC (1000)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .seg_sel     (seg_sel),
    .seg_ment    (seg_ment),
    .digit_val   (digit_val),
    .digit_blank (digit_blank),
    .digit_bad   (digit_bad),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_stale (frame_stale)
  );

  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_total = 0;
  int err_total = 0;
  logic [23:0] obs_q[$];

  always @(negedge sys_clk) begin
    if (frame_valid === 1'b1) begin
      fv_total++;
      obs_q.push_back({digit_val, digit_blank, digit_bad});
    end
    if (frame_err === 1'b1) err_total++;
  end

  // Active-high glyph values, index = nibble.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic do_reset();
    seg_sel  = 4'hF;
    seg_ment = 7'h7F;
    sys_rst  = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  // sel/seg given active-high; the bus itself is active-low.
  task automatic slot(input logic [3:0] sel_act, input logic [6:0] seg_act, input int n);
    seg_sel  = ~sel_act;
    seg_ment = ~seg_act;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pass(input logic [27:0] segs, input int n);
    for (int i = 0; i < 4; i++) slot(4'b0001 << i, segs[7*i +: 7], n);
    slot(4'b0000, 7'h00, 4);
  endtask

  typedef struct {
    logic [27:0] segs;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  bad;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    int         n;
  } slot_t;

  function automatic logic [5:0] ref_decode(input logic [6:0] seg);
    logic [5:0] r;
    r = (seg == 7'h00) ? 6'b01_0000 : 6'b10_0000;
    for (int v = 0; v < 16; v++) if (glyph[v] == seg) r = {2'b00, 4'(v)};
    return r;
  endfunction

  task automatic random_round(input int round);
    slot_t       slots[$];
    slot_t       s;
    int          prev, r, i, j, tot, d, fvb, eb, ob, exp_err;
    int          cap_idx[$];
    logic [6:0]  cap_seg[$];
    logic [23:0] exp_q[$];
    logic [23:0] last_pub, frame;
    logic [3:0]  nib[4];
    logic        bl[4], bd[4];
    logic [3:0]  seen;
    logic [5:0]  dd;
    bit          collecting;
    logic [6:0]  bad_pats[3] = '{7'h01, 7'h40, 7'h7E};

    prev = 3;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        case ($urandom_range(0, 2))
          0:       s.sel = 4'b0000;
          1:       s.sel = 4'b0011;
          default: s.sel = 4'b1111;
        endcase
      end else begin
        prev  = ($urandom_range(0, 9) < 8) ? (prev + 1) % 4 : int'($urandom_range(0, 3));
        s.sel = 4'b0001 << prev;
      end
      r = $urandom_range(0, 19);
      if (r < 16) s.seg = glyph[r];
      else if (r == 16) s.seg = 7'h00;
      else if (r == 17) s.seg = bad_pats[$urandom_range(0, 2)];
      else s.seg = glyph[$urandom_range(0, 15)];
      s.n = ($urandom_range(0, 9) < 8) ? int'($urandom_range(8, 16)) : int'($urandom_range(3, 7));
      slots.push_back(s);
    end
    s.sel = 4'b0000; s.seg = 7'h00; s.n = 8;
    slots.push_back(s);

    // A slot is captured when its (merged) run is one-hot and long enough.
    i = 0;
    while (i < slots.size()) begin
      j = i; tot = 0;
      while (j < slots.size() && slots[j].sel == slots[i].sel && slots[j].seg == slots[i].seg) begin
        tot += slots[j].n;
        j++;
      end
      if ($countones(slots[i].sel) == 1 && tot >= StableCnt) begin
        d = 0;
        for (int b = 0; b < 4; b++) if (slots[i].sel[b]) d = b;
        cap_idx.push_back(d);
        cap_seg.push_back(slots[i].seg);
      end
      i = j;
    end

    collecting = 0; seen = 4'h0; exp_err = 0; last_pub = '0;
    for (int b = 0; b < 4; b++) begin nib[b] = 0; bl[b] = 0; bd[b] = 0; end
    for (int k = 0; k < cap_idx.size(); k++) begin
      d  = cap_idx[k];
      dd = ref_decode(cap_seg[k]);
      if (!collecting && d != 0) continue;
      if (d == 0) begin
        if (collecting) exp_err++;
        for (int b = 0; b < 4; b++) begin nib[b] = 0; bl[b] = 0; bd[b] = 0; end
        seen = 4'h0;
        collecting = 1;
      end
      nib[d] = dd[3:0]; bl[d] = dd[4]; bd[d] = dd[5]; seen[d] = 1'b1;
      if (seen == 4'hF) begin
        frame = {nib[3], nib[2], nib[1], nib[0], bl[3], bl[2], bl[1], bl[0],
                 bd[3], bd[2], bd[1], bd[0]};
`ifdef SEG_SCAN_RX_CHANGE_ONLY_EN
        if (frame != last_pub) exp_q.push_back(frame);
`else
        exp_q.push_back(frame);
`endif
        last_pub = frame;
        collecting = 0;
        seen = 4'h0;
      end
    end

    do_reset();
    fvb = fv_total; eb = err_total; ob = obs_q.size();
    foreach (slots[k]) slot(slots[k].sel, slots[k].seg, slots[k].n);
    check($sformatf("rand%0d frame count", round), fv_total - fvb, exp_q.size());
    check($sformatf("rand%0d err count", round), err_total - eb, exp_err);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (ob + k < obs_q.size())
        check($sformatf("rand%0d frame %0d", round, k), obs_q[ob + k], exp_q[k]);
    end
  endtask

  vec_t tbl[5];
  int   fvb, eb, exp_n;
  logic stale_early;

  initial begin
    tbl[0] = '{{7'h4F, 7'h5B, 7'h06, 7'h3F}, 16'h3210, 4'b0000, 4'b0000};
    tbl[1] = '{{7'h07, 7'h7D, 7'h6D, 7'h66}, 16'h7654, 4'b0000, 4'b0000};
    tbl[2] = '{{7'h7C, 7'h77, 7'h6F, 7'h7F}, 16'hBA98, 4'b0000, 4'b0000};
    tbl[3] = '{{7'h71, 7'h79, 7'h5E, 7'h39}, 16'hFEDC, 4'b0000, 4'b0000};
    tbl[4] = '{{7'h01, 7'h00, 7'h06, 7'h3F}, 16'h0010, 4'b0100, 4'b1000};

    // Reset state.
    do_reset();
    check("reset digit_val", digit_val, 16'h0);
    check("reset digit_blank", digit_blank, 4'h0);
    check("reset digit_bad", digit_bad, 4'h0);
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset frame_stale", frame_stale, 1'b0);

    // Decode table.
    for (int t = 0; t < 5; t++) begin
      fvb = fv_total;
      pass(tbl[t].segs, 20);
      check($sformatf("tbl%0d frames", t), fv_total - fvb, 1);
      check($sformatf("tbl%0d digit_val", t), digit_val, tbl[t].val);
      check($sformatf("tbl%0d digit_blank", t), digit_blank, tbl[t].blank);
      check($sformatf("tbl%0d digit_bad", t), digit_bad, tbl[t].bad);
    end

    // Three identical 50-cycle passes, then digit 1 changes.
    do_reset();
    fvb = fv_total;
    for (int p = 0; p < 3; p++) pass(tbl[0].segs, 50);
`ifdef SEG_SCAN_RX_CHANGE_ONLY_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    check("repeat frames", fv_total - fvb, exp_n);
    check("repeat digit_val", digit_val, 16'h3210);
    pass({7'h4F, 7'h5B, 7'h5B, 7'h3F}, 50);
    check("changed frames", fv_total - fvb, exp_n + 1);
    check("changed digit_val", digit_val, 16'h3220);

    // Slots too short to capture; timeout runs out.
    do_reset();
    fvb = fv_total;
    stale_early = 1'b1;
    for (int c = 0; c < 1020; c++) begin
      seg_sel  = ~(4'b0001 << ((c / 6) % 4));
      seg_ment = ~glyph[(c / 6) % 4];
      @(posedge sys_clk);
      #1;
      if (c == 985) stale_early = frame_stale;
    end
    check("short no frames", fv_total - fvb, 0);
    check("stale before timeout", stale_early, 1'b0);
    check("stale after timeout", frame_stale, 1'b1);
    check("stale holds outputs", digit_val, 16'h0);
    pass(tbl[1].segs, 20);
    check("stale cleared", frame_stale, 1'b0);

    // Digit 0 reappears before the frame completes.
    do_reset();
    fvb = fv_total; eb = err_total;
    slot(4'b0001, 7'h3F, 20);
    slot(4'b0010, 7'h06, 20);
    slot(4'b0001, 7'h3F, 20);
    check("abort err pulse", err_total - eb, 1);
    check("abort no frame", fv_total - fvb, 0);
    slot(4'b0010, 7'h06, 20);
    slot(4'b0100, 7'h5B, 20);
    slot(4'b1000, 7'h4F, 20);
    slot(4'b0000, 7'h00, 4);
    check("after abort frames", fv_total - fvb, 1);
    check("after abort digit_val", digit_val, 16'h3210);

    // Guard and ghost selects between slots.
    do_reset();
    fvb = fv_total; eb = err_total;
    for (int i = 0; i < 4; i++) begin
      slot(4'b0000, tbl[0].segs[7*i +: 7], 3);
      slot(4'b0011, tbl[0].segs[7*i +: 7], 3);
      slot(4'b0001 << i, tbl[0].segs[7*i +: 7], 20);
    end
    slot(4'b0000, 7'h00, 4);
    check("glitch frames", fv_total - fvb, 1);
    check("glitch errs", err_total - eb, 0);
    check("glitch digit_val", {digit_val, digit_blank, digit_bad}, {16'h3210, 8'h00});

    // Reset in the middle of collecting.
    do_reset();
    pass(tbl[3].segs, 20);
    slot(4'b0001, 7'h3F, 20);
    slot(4'b0010, 7'h06, 20);
    sys_rst = 1'b1;
    #1;
    check("midreset outputs", {digit_val, digit_blank, digit_bad}, 24'h0);
    check("midreset pulses", {frame_valid, frame_err, frame_stale}, 3'b000);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    fvb = fv_total;
    slot(4'b0010, 7'h06, 20);
    slot(4'b0100, 7'h5B, 20);
    slot(4'b1000, 7'h4F, 20);
    check("post reset needs digit0", fv_total - fvb, 0);
    pass(tbl[0].segs, 20);
    check("post reset frame", fv_total - fvb, 1);
    check("post reset digit_val", digit_val, 16'h3210);

    for (int r = 0; r < 3; r++) random_round(r);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
